// File: rtl/risc_v_cpu_m00_axil_master.sv
// AXI4-Lite master self-test engine: on an INIT_AXI_TXN rising edge it writes N words
// to the target slave, reads them back, and flags any data mismatch or non-OKAY response.
module risc_v_cpu_m00_axil_master #(
  parameter logic [31:0] C_M_TARGET_SLAVE_BASE_ADDR = 32'h4000_0000,
  parameter int          C_M_AXI_ADDR_WIDTH         = 32,
  parameter int          C_M_AXI_DATA_WIDTH         = 32,
  parameter int          C_M_TRANSACTIONS_NUM       = 4,
  parameter logic [31:0] C_DATA_SEED                = 32'hA5A5_0000
) (
  input  logic                              ACLK,
  input  logic                              ARESETN,
  input  logic                              INIT_AXI_TXN,
  output logic                              TXN_DONE,
  output logic                              ERROR,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                        M_AXI_AWPROT,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [2:0]                        M_AXI_ARPROT,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY
);

  localparam int              AW   = C_M_AXI_ADDR_WIDTH;
  localparam int              DW   = C_M_AXI_DATA_WIDTH;
  localparam logic [AW-1:0]   BASE = AW'(C_M_TARGET_SLAVE_BASE_ADDR);
  localparam logic [DW-1:0]   SEED = DW'(C_DATA_SEED);
  localparam logic [7:0]      LAST = 8'(C_M_TRANSACTIONS_NUM - 1);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  state_t          state_q, state_d;
  logic            init_q;
  logic [7:0]      idx;
  logic            awvalid, wvalid, bready, arvalid, rready;
  logic            aw_done, w_done;
  logic            txn_done, error;
  logic [AW-1:0]   awaddr, araddr;
  logic [DW-1:0]   wdata;

  logic            init_edge, start, last;
  logic            aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic            rd_bad;

  function automatic logic [AW-1:0] addr_of(input logic [7:0] k);
    addr_of = BASE + (AW'(k) << 2);
  endfunction

  function automatic logic [DW-1:0] data_of(input logic [7:0] k);
    data_of = SEED + DW'(k);
  endfunction

  assign init_edge = INIT_AXI_TXN && !init_q;
  assign start     = init_edge && ((state_q == IDLE) || (state_q == DONE));
  assign last      = (idx == LAST);

  assign aw_hs = (state_q == WRITE) && awvalid && M_AXI_AWREADY;
  assign w_hs  = (state_q == WRITE) && wvalid  && M_AXI_WREADY;
  assign b_hs  = (state_q == WRITE) && bready  && M_AXI_BVALID;
  assign ar_hs = (state_q == READ)  && arvalid && M_AXI_ARREADY;
  assign r_hs  = (state_q == READ)  && rready  && M_AXI_RVALID;

  assign rd_bad = (M_AXI_RDATA != data_of(idx)) || (M_AXI_RRESP != 2'b00);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (start)        state_d = WRITE;
      WRITE:      if (b_hs && last) state_d = READ;
      READ:       if (r_hs && last) state_d = DONE;
      default:                      state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      init_q   <= 1'b0;
      idx      <= '0;
      awvalid  <= 1'b0;
      wvalid   <= 1'b0;
      bready   <= 1'b0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      arvalid  <= 1'b0;
      rready   <= 1'b0;
      awaddr   <= '0;
      araddr   <= '0;
      wdata    <= '0;
      txn_done <= 1'b0;
      error    <= 1'b0;
    end else begin
      init_q <= INIT_AXI_TXN;

      if (start) begin
        idx      <= '0;
        awvalid  <= 1'b1;
        wvalid   <= 1'b1;
        aw_done  <= 1'b0;
        w_done   <= 1'b0;
        awaddr   <= addr_of(8'd0);
        wdata    <= data_of(8'd0);
        txn_done <= 1'b0;
        error    <= 1'b0;
      end

      // Write channel: AW and W retire independently; B is accepted only once both have.
      if (aw_hs) begin
        awvalid <= 1'b0;
        aw_done <= 1'b1;
      end
      if (w_hs) begin
        wvalid <= 1'b0;
        w_done <= 1'b1;
      end
      if ((state_q == WRITE) && !bready && (aw_done || aw_hs) && (w_done || w_hs))
        bready <= 1'b1;

      if (b_hs) begin
        bready  <= 1'b0;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        if (M_AXI_BRESP != 2'b00) error <= 1'b1;
        if (last) begin
          idx     <= '0;
          arvalid <= 1'b1;
          araddr  <= addr_of(8'd0);
        end else begin
          idx     <= idx + 8'd1;
          awvalid <= 1'b1;
          wvalid  <= 1'b1;
          awaddr  <= addr_of(idx + 8'd1);
          wdata   <= data_of(idx + 8'd1);
        end
      end

      // Read channel: one AR outstanding, data compared on the R handshake.
      if (ar_hs) begin
        arvalid <= 1'b0;
        rready  <= 1'b1;
      end

      if (r_hs) begin
        rready <= 1'b0;
        if (rd_bad) error <= 1'b1;
        if (last) begin
          txn_done <= 1'b1;
        end else begin
          idx     <= idx + 8'd1;
          arvalid <= 1'b1;
          araddr  <= addr_of(idx + 8'd1);
        end
      end
    end
  end

  assign TXN_DONE      = txn_done;
  assign ERROR         = error;
  assign M_AXI_AWADDR  = awaddr;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid;
  assign M_AXI_WDATA   = wdata;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WVALID  = wvalid;
  assign M_AXI_BREADY  = bready;
  assign M_AXI_ARADDR  = araddr;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = arvalid;
  assign M_AXI_RREADY  = rready;

endmodule
